// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory slave.
package mem_responder_pkg;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_READ  = 3'd1,
    M_WRITE = 3'd2,
    M_LOAD  = 3'd3,
    M_ERR   = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-write-port storage with a registered, write-first read port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write port.
  // NOTE: the array has no reset so it maps onto RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: cleared by reset, otherwise holds until the next read.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU/host memory responder: strobe-decoding FSM, write-edge detection,
// sticky conflict error, and a mem_array for storage.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  wr_done,
  output logic                  err
);

  mem_state_t state;
  mem_state_t state_next;

  logic       prev_wr;
  logic [1:0] strobe_cnt;
  logic       conflict;
  logic       do_read;
  logic       do_commit;
  logic       do_load;

  assign strobe_cnt = {1'b0, mem_rd} + {1'b0, mem_wr} + {1'b0, ld_en};
  assign conflict   = (strobe_cnt > 2'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= M_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: M_ERR is absorbing; otherwise the strobe selects.
  // NOTE: defaulting every always_comb output first prevents inferred latches.
  always_comb begin
    state_next = state;
    if (state != M_ERR) begin
      if (conflict)    state_next = M_ERR;
      else if (mem_rd) state_next = M_READ;
      else if (mem_wr) state_next = M_WRITE;
      else if (ld_en)  state_next = M_LOAD;
      else             state_next = M_IDLE;
    end
  end

  // Action decode: nothing happens in M_ERR, on a conflict, or under reset.
  always_comb begin
    do_read   = 1'b0;
    do_commit = 1'b0;
    do_load   = 1'b0;
    err       = (state == M_ERR);
    if ((state != M_ERR) && !conflict && !rst) begin
      do_read   = mem_rd;
      do_commit = mem_wr && !prev_wr;
      do_load   = ld_en;
    end
  end

  // Registered handshakes and the write-edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      wr_done    <= 1'b0;
      prev_wr    <= 1'b0;
    end else begin
      data_valid <= do_read;
      wr_done    <= do_commit;
      prev_wr    <= mem_wr;
    end
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (do_commit || do_load),
    .waddr (do_load ? ld_addr : addr),
    .wdata (do_load ? ld_data : data_in),
    .re    (do_read),
    .raddr (addr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver updates a behavioural model
// and queues expected responses; a monitor checks them after each edge.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic       mem_rd;
  logic       mem_wr;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       wr_done;
  logic       err;

  mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .wr_done    (wr_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] ref_mem [32];
  logic [7:0] rd_q [$];
  logic       model_err = 1'b0;
  logic       model_prev = 1'b0;
  logic       wr_pend = 1'b0;
  logic [7:0] last_out = 8'h00;
  logic       mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the model to the upcoming edge.
  task automatic step(input logic r, input logic rd, input logic wr, input logic ld,
                      input logic [4:0] a, input logic [7:0] d,
                      input logic [4:0] la, input logic [7:0] lv);
    int n;
    @(negedge clk);
    #1;
    rst = r; mem_rd = rd; mem_wr = wr; ld_en = ld;
    addr = a; data_in = d; ld_addr = la; ld_data = lv;
    mon_on = 1'b1;
    if (r) begin
      model_err  = 1'b0;
      model_prev = 1'b0;
      last_out   = 8'h00;
    end else begin
      n = int'(rd) + int'(wr) + int'(ld);
      if (!model_err) begin
        if (n > 1)                  model_err = 1'b1;
        else if (rd)                rd_q.push_back(ref_mem[a]);
        else if (wr && !model_prev) begin ref_mem[a] = d; wr_pend = 1'b1; end
        else if (ld)                ref_mem[la] = lv;
      end
      model_prev = wr;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 5'd0, 8'h00);
  endtask

  task automatic rd_at(input logic [4:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00, 5'd0, 8'h00);
  endtask

  task automatic wr_at(input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, 1'b0, a, d, 5'd0, 8'h00);
  endtask

  task automatic ld_at(input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, a, d);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 5'd0, 8'h00);
  endtask

  // Monitor: compare DUT outputs against the scoreboard just after each edge.
  always @(posedge clk) begin
    logic [7:0] e;
    logic       exp_v;
    #1;
    if (mon_on) begin
      exp_v = (rd_q.size() != 0);
      check("data_valid", {31'd0, data_valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = rd_q.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e});
        last_out = e;
      end else begin
        check("data_hold", {24'd0, data_out}, {24'd0, last_out});
      end
      check("wr_done", {31'd0, wr_done}, {31'd0, wr_pend});
      wr_pend = 1'b0;
      check("err", {31'd0, err}, {31'd0, model_err});
    end
  end

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; ld_en = 1'b0;
    addr = '0; data_in = '0; ld_addr = '0; ld_data = '0;

    do_reset();
    do_reset();
    // Preload the whole array so every later read has a known value.
    for (int i = 0; i < 32; i++) ld_at(5'(i), 8'($urandom_range(0, 255)));
    idle();

    // Load then single read.
    ld_at(5'd3, 8'hA5);
    rd_at(5'd3);
    idle();
    idle();

    // Held write: one commit only, then read back.
    wr_at(5'd7, 8'h3C);
    wr_at(5'd7, 8'h3C);
    wr_at(5'd7, 8'h3C);
    idle();
    rd_at(5'd7);
    // Second write edge after one low cycle.
    idle();
    wr_at(5'd7, 8'h11);
    idle();
    rd_at(5'd7);
    rd_at(5'd7);
    rd_at(5'd31);
    idle();

    // Read-after-write at the top address.
    wr_at(5'd31, 8'h55);
    rd_at(5'd31);
    idle();

    // Held read with changing addresses.
    for (int i = 0; i < 6; i++) rd_at(5'(i * 5));
    idle();

    // Conflict: sticky error, strobes ignored, address 2 untouched.
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 8'hEE, 5'd0, 8'h00);
    rd_at(5'd2);
    wr_at(5'd2, 8'h99);
    ld_at(5'd2, 8'h77);
    rd_at(5'd2);
    do_reset();
    rd_at(5'd2);
    idle();

    // Write under reset is suppressed.
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 8'hC3, 5'd0, 8'h00);
    rd_at(5'd4);
    idle();
    // Write held across reset release commits in the first cycle after.
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 8'hD7, 5'd0, 8'h00);
    wr_at(5'd4, 8'hD7);
    wr_at(5'd4, 8'hD7);
    idle();
    rd_at(5'd4);
    idle();

    // Load under reset is suppressed.
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 5'd9, 8'h42);
    rd_at(5'd9);
    idle();

    // Randomized traffic with occasional resets and conflicts.
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [4:0] a;
      logic [7:0] d;
      sel = $urandom_range(0, 99);
      a   = 5'($urandom_range(0, 31));
      d   = 8'($urandom_range(0, 255));
      if ((i % 60) == 59)  do_reset();
      else if (sel < 30)   rd_at(a);
      else if (sel < 55)   wr_at(a, d);
      else if (sel < 70)   ld_at(a, d);
      else if (sel < 72)   step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, a, d, a, d);
      else if (sel < 74)   step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), a, d, a, d);
      else                 idle();
    end

    do_reset();
    idle();
    idle();
    check("rd_queue_drained", rd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning the word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the data word width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  access address from the CPU.
- data_in  input  DATA_WIDTH  write data (accumulator).
- mem_rd  input  1  read strobe, level; may be held for several cycles.
- mem_wr  input  1  write strobe, level; may be held for several cycles.
- ld_en  input  1  host program-load write enable.
- ld_addr  input  ADDR_WIDTH  host load address.
- ld_data  input  DATA_WIDTH  host load data.
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  data_out refreshed this cycle.
- wr_done  output  1  one-cycle pulse after a CPU write commits.
- err  output  1  sticky protocol-violation flag.

Function
REQ-005 SHALL store 2**ADDR_WIDTH words of DATA_WIDTH bits (32x8 by default).
REQ-006 SHALL run an FSM with states M_IDLE, M_READ, M_WRITE, M_LOAD and M_ERR, evaluated each rising edge.
REQ-007 FSM transitions by strobe:
- mem_rd alone -> M_READ.
- mem_wr alone -> M_WRITE.
- ld_en alone -> M_LOAD.
- no strobe -> M_IDLE.
- any two or more of mem_rd, mem_wr, ld_en in one cycle -> M_ERR.
REQ-008 Read: mem_rd high in cycle N SHALL put mem[addr] on data_out in cycle N+1, with data_valid=1 in N+1 (latency 1).
REQ-009 Held read: mem_rd high for K consecutive cycles SHALL give K consecutive data_valid cycles, each returning the address sampled one cycle earlier.
REQ-010 data_out SHALL hold its last value when no read occurred in the previous cycle; data_valid=0 in that case.
REQ-011 Write: mem_wr is edge-qualified. Only the first cycle of a mem_wr assertion (mem_wr=1, previous mem_wr=0) writes data_in to mem[addr]. Later held cycles SHALL NOT write.
REQ-012 wr_done SHALL pulse for one cycle in the cycle after each committed CPU write.
REQ-013 Read-after-write: a read in the cycle after a write to the same address SHALL return the new data.
REQ-014 ld_en SHALL write ld_data to mem[ld_addr] on every cycle it is high, with no edge qualification. It SHALL produce no wr_done and no data_valid.
REQ-015 Conflict: in a conflicting cycle (REQ-007) no memory write and no read SHALL occur.
REQ-016 Conflict SHALL set err=1. err and M_ERR SHALL remain until rst.
REQ-017 In M_ERR, all strobes SHALL be ignored, data_valid=0 and wr_done=0.
REQ-018 Address arithmetic SHALL be unsigned and full range: address 31 is valid, with no wrap or out-of-range case at the default width.

Reset
REQ-019 While rst=1 at a rising edge, the block SHALL set:
- data_out=0, data_valid=0, wr_done=0, err=0;
- state=M_IDLE;
- previous-mem_wr register=0.
REQ-020 Memory contents SHALL NOT be cleared by rst.
REQ-021 A write or load strobe coinciding with rst=1 SHALL be suppressed.
REQ-022 A mem_wr held high across reset deassertion SHALL count as a new rising edge in the first cycle after reset.

Structure
REQ-023 The shared package typedefs SHALL gain:
- enum mem_state_t (M_IDLE=0, M_READ=1, M_WRITE=2, M_LOAD=3, M_ERR=4), logic[2:0];
- constants MEM_ADDR_W=5 and MEM_DATA_W=8.
REQ-024 Storage SHALL be a sub-module mem_array: single write port, synchronous read, write-first.
REQ-025 The FSM, write-edge detector and error logic SHALL live in mem_responder.

Verification
REQ-026 Load then read: ld_en loads 0xA5 at address 3, then mem_rd for one cycle at address 3 -> data_out=0xA5 and data_valid=1 in the next cycle only.
REQ-027 Held write: data_in=0x3C, addr=7, mem_wr held for 3 cycles -> one commit and one wr_done pulse. A following read at address 7 returns 0x3C.
REQ-028 Second write edge: after REQ-027, drop mem_wr for one cycle and raise it with data_in=0x11 -> a second commit; address 7 reads 0x11.
REQ-029 Read-after-write: write 0x55 to address 31, then mem_rd at address 31 in the next cycle -> data_out=0x55.
REQ-030 Conflict: mem_rd and mem_wr both high at address 2 -> err=1 and address 2 unchanged. Later reads return data_valid=0 until rst; after rst, err=0.
REQ-031 Reset mid-write: mem_wr rises together with rst=1 at address 4 -> address 4 is unchanged. With mem_wr still high after rst falls -> a write commits and wr_done pulses.
